// File: rtl/acsi_initiator_if.sv
// ACSI bus signal bundle: the initiator drives address/select/direction/data,
// the target returns read data and its interrupt line.
interface acsi_initiator_if;
    logic       acsi_a1;
    logic       acsi_sel;
    logic       acsi_rw;
    logic [7:0] acsi_dout;
    logic [7:0] acsi_din;
    logic       acsi_irq;

    modport master (
        output acsi_a1, acsi_sel, acsi_rw, acsi_dout,
        input  acsi_din, acsi_irq
    );

    modport slave (
        input  acsi_a1, acsi_sel, acsi_rw, acsi_dout,
        output acsi_din, acsi_irq
    );
endinterface

// File: rtl/acsi_initiator.sv
// ACSI command initiator: sends one CDB (optionally ICD-prefixed) byte by byte,
// waits for completion, reads the status byte and reports done/err/timeout.
module acsi_initiator #(
    parameter int unsigned SEL_LEN      = 2,
    parameter logic [15:0] ACK_TIMEOUT  = 16'd1000,
    parameter logic [23:0] DONE_TIMEOUT = 24'd2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [2:0]       target,
    input  logic [4:0]       cmd_len,
    output logic [3:0]       cmd_idx,
    input  logic [7:0]       cmd_byte,
    output logic             busy,
    output logic             done,
    output logic [7:0]       status,
    output logic             err,
    output logic             timeout,
    acsi_initiator_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, SETUP, SEL, RECOVER, WAIT_ACK, WAIT_DONE, STAT_SETUP, STAT_SEL, FINISH
    } state_t;

    localparam logic [3:0]  SEL_LAST  = 4'(SEL_LEN - 1);
    localparam logic [23:0] ACK_LAST  = {8'd0, ACK_TIMEOUT} - 24'd1;
    localparam logic [23:0] DONE_LAST = DONE_TIMEOUT - 24'd1;

    state_t      state_q, state_d;
    logic [2:0]  target_q, target_d;
    logic [4:0]  len_q, len_d;
    logic [3:0]  idx_q, idx_d;
    logic        icd_q, icd_d;
    logic        first_q, first_d;     // current bus byte is the command's first one
    logic        rd_q, rd_d;           // status read already performed
    logic [3:0]  sel_cnt_q, sel_cnt_d;
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  status_q, status_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;

    logic        len_ok;
    logic        last_byte;
    logic [7:0]  bus_byte;

    assign len_ok    = (cmd_len >= 5'd6) && (cmd_len <= 5'd16);
    // ICD and plain modes both end on CDB index len-1 once past the first byte.
    assign last_byte = !first_q && ({1'b0, idx_q} == (len_q - 5'd1));
    assign bus_byte  = first_q ? {target_q, (icd_q ? 5'h1F : cmd_byte[4:0])} : cmd_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            target_q  <= 3'd0;
            len_q     <= 5'd0;
            idx_q     <= 4'd0;
            icd_q     <= 1'b0;
            first_q   <= 1'b0;
            rd_q      <= 1'b0;
            sel_cnt_q <= 4'd0;
            tmo_cnt_q <= 24'd0;
            status_q  <= 8'h00;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            icd_q     <= icd_d;
            first_q   <= first_d;
            rd_q      <= rd_d;
            sel_cnt_q <= sel_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            status_q  <= status_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        len_d     = len_q;
        idx_d     = idx_q;
        icd_d     = icd_q;
        first_d   = first_q;
        rd_d      = rd_q;
        sel_cnt_d = sel_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        status_d  = status_q;
        err_d     = err_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    status_d  = 8'h00;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    idx_d     = 4'd0;
                    if (len_ok) begin
                        target_d = target;
                        len_d    = cmd_len;
                        // cmd_idx is 0 while idle, so cmd_byte is CDB byte 0 here
                        icd_d    = (cmd_byte >= 8'h20);
                        first_d  = 1'b1;
                        rd_d     = 1'b0;
                        state_d  = SETUP;
                    end else begin
                        status_d = 8'h02;
                        err_d    = 1'b1;
                        state_d  = FINISH;
                    end
                end
            end
            SETUP: begin
                if (clk_en) begin
                    sel_cnt_d = 4'd0;
                    state_d   = SEL;
                end
            end
            SEL: begin
                if (clk_en) begin
                    if (sel_cnt_q == SEL_LAST) state_d = RECOVER;
                    else                       sel_cnt_d = sel_cnt_q + 4'd1;
                end
            end
            RECOVER: begin
                if (clk_en) begin
                    tmo_cnt_d = 24'd0;
                    if (rd_q)           state_d = FINISH;
                    else if (last_byte) state_d = WAIT_DONE;
                    else                state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (clk_en) begin
                    if (bus.acsi_irq) begin
                        // the ICD escape byte precedes CDB byte 0 without consuming it
                        if (!(first_q && icd_q)) idx_d = idx_q + 4'd1;
                        first_d = 1'b0;
                        state_d = SETUP;
                    end else if (tmo_cnt_q == ACK_LAST) begin
                        timeout_d = 1'b1;
                        status_d  = 8'hFF;
                        err_d     = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 24'd1;
                    end
                end
            end
            WAIT_DONE: begin
                if (clk_en) begin
                    if (bus.acsi_irq) begin
                        state_d = STAT_SETUP;
                    end else if (tmo_cnt_q == DONE_LAST) begin
                        timeout_d = 1'b1;
                        status_d  = 8'hFF;
                        err_d     = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 24'd1;
                    end
                end
            end
            STAT_SETUP: begin
                if (clk_en) begin
                    sel_cnt_d = 4'd0;
                    state_d   = STAT_SEL;
                end
            end
            STAT_SEL: begin
                if (clk_en) begin
                    if (sel_cnt_q == SEL_LAST) begin
                        status_d = bus.acsi_din;
                        err_d    = bus.acsi_din[1];
                        rd_d     = 1'b1;
                        state_d  = RECOVER;
                    end else begin
                        sel_cnt_d = sel_cnt_q + 4'd1;
                    end
                end
            end
            FINISH: begin
                idx_d   = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic       a1_o, sel_o, rw_o;
    logic [7:0] dout_o;

    always_comb begin
        a1_o   = 1'b0;
        sel_o  = 1'b0;
        rw_o   = 1'b1;
        dout_o = 8'h00;
        unique case (state_q)
            SETUP, SEL: begin
                a1_o   = !first_q;
                rw_o   = 1'b0;
                dout_o = bus_byte;
                sel_o  = (state_q == SEL);
            end
            RECOVER: begin
                a1_o   = !(first_q || rd_q);
                dout_o = rd_q ? 8'h00 : bus_byte;
            end
            WAIT_ACK, WAIT_DONE: a1_o = 1'b1;
            STAT_SETUP, STAT_SEL: sel_o = (state_q == STAT_SEL);
            default: ;
        endcase
    end

    assign bus.acsi_a1   = a1_o;
    assign bus.acsi_sel  = sel_o;
    assign bus.acsi_rw   = rw_o;
    assign bus.acsi_dout = dout_o;

    assign cmd_idx = idx_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);
    assign status  = status_q;
    assign err     = err_q;
    assign timeout = timeout_q;

endmodule
